// File: rtl/cache_controller_if.sv
// Bus bundle between the MEM stage, the data cache and the SRAM controller.
// The cache uses the slave view; the environment (pipeline plus SRAM
// controller) uses the master view.
interface cache_controller_if;
    // MEM-stage request side
    logic [31:0] address;
    logic [31:0] wdata;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] rdata;
    logic        ready;
    // SRAM controller side
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    modport slave (
        input  address, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
        output rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
    );

    modport master (
        output address, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
        input  rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
    );
endinterface

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache.
// Read hits complete in the request cycle; read misses fetch a 64-bit block
// from SRAM and fill a victim way; stores go straight to SRAM and drop any
// cached copy of the block. ready=0 stalls the pipeline while SRAM is busy.
module cache_controller #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 10
) (
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.slave  bus
);
    localparam int SETS = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR      = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [1:0][SETS-1:0]       valid_q;
    logic [SETS-1:0]            lru_q;
    logic [TAG_BITS-1:0]        tag_q  [2][SETS];
    logic [63:0]                data_q [2][SETS];

    logic [INDEX_BITS-1:0]      idx_s;
    logic [TAG_BITS-1:0]        tag_s;
    logic                       wsel_s;
    logic [1:0]                 hit_s;
    logic                       hit_any_s;
    logic                       hit_way_s;
    logic                       victim_s;
    logic                       fill_s;
    logic                       inval_s;
    logic                       lru_we_s;
    logic                       lru_val_s;

    // Pick the addressed 32-bit word out of a 64-bit block.
    function automatic logic [31:0] sel_word(input logic [63:0] blk, input logic hi);
        return hi ? blk[63:32] : blk[31:0];
    endfunction

    assign idx_s     = bus.address[3 +: INDEX_BITS];
    assign tag_s     = bus.address[3 + INDEX_BITS +: TAG_BITS];
    assign wsel_s    = bus.address[2];
    assign hit_s[0]  = valid_q[0][idx_s] && (tag_q[0][idx_s] == tag_s);
    assign hit_s[1]  = valid_q[1][idx_s] && (tag_q[1][idx_s] == tag_s);
    assign hit_any_s = hit_s[0] | hit_s[1];
    assign hit_way_s = hit_s[1];

    // Victim selection: fill empty ways first, otherwise replace the LRU way.
    always_comb begin
        if (!valid_q[0][idx_s]) begin
            victim_s = 1'b0;
        end else if (!valid_q[1][idx_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_q[idx_s];
        end
    end

    // Next-state and output decode; idle defaults keep ready high and SRAM quiet.
    always_comb begin
        state_d          = state_q;
        bus.ready        = 1'b1;
        bus.rdata        = 32'd0;
        bus.sram_address = 32'd0;
        bus.sram_wdata   = 32'd0;
        bus.sram_r_en    = 1'b0;
        bus.sram_w_en    = 1'b0;
        fill_s           = 1'b0;
        inval_s          = 1'b0;
        lru_we_s         = 1'b0;
        lru_val_s        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_w_en) begin
                    // Stores win over a simultaneous load and never allocate.
                    bus.ready = 1'b0;
                    inval_s   = hit_any_s;
                    state_d   = WR;
                end else if (bus.mem_r_en) begin
                    if (hit_any_s) begin
                        bus.rdata = sel_word(data_q[hit_way_s][idx_s], wsel_s);
                        lru_we_s  = 1'b1;
                        lru_val_s = ~hit_way_s;
                    end else begin
                        bus.ready = 1'b0;
                        state_d   = RD_MISS;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_MISS: begin
                bus.sram_r_en    = 1'b1;
                bus.sram_address = {bus.address[31:3], 3'b000};
                if (bus.sram_ready) begin
                    bus.rdata = sel_word(bus.sram_rdata, wsel_s);
                    fill_s    = 1'b1;
                    lru_we_s  = 1'b1;
                    lru_val_s = ~victim_s;
                    state_d   = IDLE;
                end else begin
                    bus.ready = 1'b0;
                end
            end
            WR: begin
                bus.sram_w_en    = 1'b1;
                bus.sram_address = bus.address;
                bus.sram_wdata   = bus.wdata;
                if (bus.sram_ready) begin
                    state_d = IDLE;
                end else begin
                    bus.ready = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Valid and LRU bookkeeping; reset empties the whole cache.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            if (fill_s) begin
                valid_q[victim_s][idx_s] <= 1'b1;
            end else if (inval_s) begin
                if (hit_s[0]) valid_q[0][idx_s] <= 1'b0;
                if (hit_s[1]) valid_q[1][idx_s] <= 1'b0;
            end
            if (lru_we_s) begin
                lru_q[idx_s] <= lru_val_s;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (rst && fill_s) begin
            tag_q[victim_s][idx_s]  <= tag_s;
            data_q[victim_s][idx_s] <= bus.sram_rdata;
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: a table of loads/stores with
// expected hit/miss behaviour, a reference memory feeding a scoreboard of
// expected load data, an SRAM controller model with fixed latency, and
// hand-written sequences for reset during a miss and the dual-enable case.
module tb_cache_controller;
    localparam int LAT = 5;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    cache_controller_if bus ();

    cache_controller #(.INDEX_BITS(6), .TAG_BITS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference contents seen by the pipeline, and the SRAM model's storage.
    logic [63:0] ref_mem  [logic [28:0]];
    logic [63:0] sram_mem [logic [28:0]];
    logic [31:0] sb [$];

    function automatic logic [63:0] dflt_block(input logic [28:0] ba);
        return {32'hB000_0000 | {3'b000, ba}, 32'hA000_0000 | {3'b000, ba}};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [63:0] blk;
        blk = ref_mem.exists(a[31:3]) ? ref_mem[a[31:3]] : dflt_block(a[31:3]);
        return a[2] ? blk[63:32] : blk[31:0];
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        logic [63:0] blk;
        blk = ref_mem.exists(a[31:3]) ? ref_mem[a[31:3]] : dflt_block(a[31:3]);
        if (a[2]) blk[63:32] = d;
        else      blk[31:0]  = d;
        ref_mem[a[31:3]] = blk;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SRAM controller model: ready pulses LAT cycles after an enable rises.
    initial begin
        int cnt;
        logic [63:0] blk;
        cnt = 0;
        bus.sram_ready = 1'b0;
        bus.sram_rdata = 64'd0;
        forever begin
            @(posedge clk);
            #2;
            bus.sram_ready = 1'b0;
            if (!rst) begin
                cnt = 0;
            end else if (bus.sram_r_en || bus.sram_w_en) begin
                cnt++;
                if (cnt == LAT + 1) begin
                    cnt = 0;
                    bus.sram_ready = 1'b1;
                    blk = sram_mem.exists(bus.sram_address[31:3]) ?
                          sram_mem[bus.sram_address[31:3]] : dflt_block(bus.sram_address[31:3]);
                    if (bus.sram_r_en) begin
                        bus.sram_rdata = blk;
                    end else begin
                        if (bus.sram_address[2]) blk[63:32] = bus.sram_wdata;
                        else                     blk[31:0]  = bus.sram_wdata;
                        sram_mem[bus.sram_address[31:3]] = blk;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic do_load(input logic [31:0] a, input bit exp_hit);
        int waits;
        bit done, saw_r, saw_w, addr_ok;
        logic [31:0] exp;
        sb.push_back(ref_word(a));
        bus.address  = a;
        bus.wdata    = 32'd0;
        bus.mem_r_en = 1'b1;
        bus.mem_w_en = 1'b0;
        waits = 0; done = 1'b0; saw_r = 1'b0; saw_w = 1'b0; addr_ok = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.sram_r_en) begin
                saw_r = 1'b1;
                if (bus.sram_address !== {a[31:3], 3'b000}) addr_ok = 1'b0;
            end
            if (bus.sram_w_en) saw_w = 1'b1;
            if (bus.ready) begin
                done = 1'b1;
                exp = sb.pop_front();
                check($sformatf("load_rdata@%h", a), {32'd0, bus.rdata}, {32'd0, exp});
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        bus.mem_r_en = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL load_timeout@%h: got no ready required ready within 40 cycles", a);
            void'(sb.pop_front());
        end else begin
            check($sformatf("load_waits@%h", a), 64'(waits), exp_hit ? 64'd0 : 64'(LAT + 1));
            check($sformatf("load_sram_req@%h", a), {61'd0, saw_r, saw_w, addr_ok},
                  {61'd0, !exp_hit, 1'b0, 1'b1});
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit also_read);
        int waits;
        bit done, saw_r, saw_w, bus_ok;
        bus.address  = a;
        bus.wdata    = d;
        bus.mem_w_en = 1'b1;
        bus.mem_r_en = also_read;
        waits = 0; done = 1'b0; saw_r = 1'b0; saw_w = 1'b0; bus_ok = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.sram_r_en) saw_r = 1'b1;
            if (bus.sram_w_en) begin
                saw_w = 1'b1;
                if (bus.sram_address !== a || bus.sram_wdata !== d) bus_ok = 1'b0;
            end
            if (bus.ready) done = 1'b1;
            else           waits++;
            @(posedge clk);
            #1;
        end
        bus.mem_w_en = 1'b0;
        bus.mem_r_en = 1'b0;
        ref_write(a, d);
        if (!done) begin
            checks++; errors++;
            $display("FAIL store_timeout@%h: got no ready required ready within 40 cycles", a);
        end else begin
            check($sformatf("store_waits@%h", a), 64'(waits), 64'(LAT + 1));
            check($sformatf("store_sram_req@%h", a), {61'd0, saw_r, saw_w, bus_ok},
                  {61'd0, 1'b0, 1'b1, 1'b1});
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          store;
        logic [31:0] wdata;
        bit          exp_hit;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        ref_mem[29'h80]  = 64'h2222_2222_1111_1111;
        sram_mem[29'h80] = 64'h2222_2222_1111_1111;

        vecs[0]  = '{32'h0000_0400, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{32'h0000_0404, 1'b0, 32'h0,         1'b1};
        vecs[2]  = '{32'h0000_0600, 1'b0, 32'h0,         1'b0};
        vecs[3]  = '{32'h0000_0604, 1'b0, 32'h0,         1'b1};
        vecs[4]  = '{32'h0000_0800, 1'b0, 32'h0,         1'b0};
        vecs[5]  = '{32'h0000_0600, 1'b0, 32'h0,         1'b1};
        vecs[6]  = '{32'h0000_0400, 1'b0, 32'h0,         1'b0};
        vecs[7]  = '{32'h0000_0404, 1'b0, 32'h0,         1'b1};
        vecs[8]  = '{32'h0000_0400, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[9]  = '{32'h0000_0400, 1'b0, 32'h0,         1'b0};
        vecs[10] = '{32'h0000_0800, 1'b1, 32'h1234_5678, 1'b0};
        vecs[11] = '{32'h0000_0800, 1'b0, 32'h0,         1'b0};
        vecs[12] = '{32'h0000_0804, 1'b0, 32'h0,         1'b1};
        vecs[13] = '{32'h0000_0400, 1'b0, 32'h0,         1'b1};
        vecs[14] = '{32'h0000_0008, 1'b0, 32'h0,         1'b0};
        vecs[15] = '{32'h0000_000C, 1'b0, 32'h0,         1'b1};

        rst          = 1'b0;
        bus.address  = 32'd0;
        bus.wdata    = 32'd0;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready",     {63'd0, bus.ready},     64'd1);
        check("rst_sram_r_en", {63'd0, bus.sram_r_en}, 64'd0);
        check("rst_sram_w_en", {63'd0, bus.sram_w_en}, 64'd0);
        check("rst_rdata",     {32'd0, bus.rdata},     64'd0);
        check("rst_sram_addr", {32'd0, bus.sram_address}, 64'd0);
        check("rst_sram_wdata", {32'd0, bus.sram_wdata},  64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].store) do_store(vecs[i].addr, vecs[i].wdata, 1'b0);
            else               do_load(vecs[i].addr, vecs[i].exp_hit);
        end

        // Reset two cycles after sram_r_en rises on a miss to 0xC00.
        bus.address  = 32'h0000_0C00;
        bus.mem_r_en = 1'b1;
        @(negedge clk);
        check("rmiss_t0_ready", {63'd0, bus.ready}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rmiss_t1_r_en", {63'd0, bus.sram_r_en}, 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.mem_r_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rmiss_rst_r_en",  {63'd0, bus.sram_r_en}, 64'd0);
        check("rmiss_rst_ready", {63'd0, bus.ready},     64'd1);
        @(posedge clk); #1;
        do_load(32'h0000_0400, 1'b0);

        // Both enables: the store path must win.
        do_store(32'h0000_1000, 32'hCAFE_F00D, 1'b1);
        do_load(32'h0000_1000, 1'b0);
        do_load(32'h0000_1000, 1'b1);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage's memory request port and the SRAM controller. It removes the multi-cycle SRAM penalty on read hits. It drives the pipeline-wide `ready` that freezes IF/ID/EXE/MEM registers while an SRAM transaction is outstanding. It consumes 64-bit SRAM read blocks and 32-bit MEM-stage requests.

## Interface
- `INDEX_BITS`, default 6: set index width; 2^INDEX_BITS sets.
- `TAG_BITS`, default 10: stored tag width.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-low reset.
- `address` input 32: byte address from MEM stage; held stable while `ready`=0.
- `wdata` input 32: store data.
- `mem_r_en` input 1: load request.
- `mem_w_en` input 1: store request.
- `rdata` output 32: load data; valid when `ready`=1 and `mem_r_en`=1.
- `ready` output 1: request complete / no request pending; 0 freezes pipeline.
- `sram_address` output 32: address to SRAM controller.
- `sram_wdata` output 32: store data to SRAM controller.
- `sram_r_en` output 1: SRAM block read request.
- `sram_w_en` output 1: SRAM word write request.
- `sram_rdata` input 64: block returned by SRAM controller; valid with `sram_ready`.
- `sram_ready` input 1: SRAM transaction done, one-cycle pulse.

## Operation
- Address split:
  - word select = `address[2]`: 0 selects low word `[31:0]`, 1 selects high word `[63:32]`.
  - index = `address[3+INDEX_BITS-1:3]`.
  - tag = next TAG_BITS bits.
  - `address[1:0]` ignored.
- Storage:
  - per set and way: valid bit, tag, 64-bit data.
  - per set: one LRU bit naming the way to replace next.
  - Reset clears all valid and LRU bits. Data and tag arrays are not reset.
- FSM states: IDLE, RD_MISS, WR.
- IDLE, no request: `ready`=1, `sram_r_en`=`sram_w_en`=0.
- IDLE, `mem_r_en` and hit:
  - `rdata` = selected word of the hit way, combinationally.
  - `ready`=1.
  - At the edge, LRU <= other way.
- IDLE, `mem_r_en` and miss: `ready`=0; next state RD_MISS.
- RD_MISS:
  - `sram_r_en`=1, `sram_address`={`address[31:3]`,3'b000}.
  - `ready`=0 until `sram_ready`.
  - In the `sram_ready` cycle:
    - `rdata` = selected word of `sram_rdata`, `ready`=1.
    - At the edge: fill victim way with valid=1, tag, data; LRU <= other way; next state IDLE.
  - Victim choice: way0 if invalid, else way1 if invalid, else the LRU way.
- IDLE, `mem_w_en`:
  - `ready`=0; next state WR.
  - A hit way is invalidated at this edge. Stores never allocate.
- WR:
  - `sram_w_en`=1, `sram_address`=`address`, `sram_wdata`=`wdata`.
  - `ready`=1 in the `sram_ready` cycle; next state IDLE.
- `mem_r_en` and `mem_w_en` both 1 is illegal; the write takes priority.
- `sram_r_en` and `sram_w_en` are never both 1.

## Timing
- Reset values:
  - state IDLE.
  - `ready`=1, `sram_r_en`=0, `sram_w_en`=0.
  - `rdata`=0, `sram_address`=0, `sram_wdata`=0 while no request.
- Read hit: zero wait cycles; `ready` stays 1.
- Read miss with SRAM latency L (cycles from `sram_r_en` high to `sram_ready`):
  - request cycle T0: `ready`=0.
  - `sram_r_en` high from T1.
  - `ready`=1 at T1+L; IDLE at T2+L.
- Write: same shape as a read miss, using `sram_w_en`.
- Pipeline advances on the same edge the FSM returns to IDLE. The next request is evaluated in IDLE the following cycle.
- A request arriving back-to-back to the just-filled block hits.
- Reset asserted during RD_MISS/WR:
  - return to IDLE next edge; SRAM enables drop that cycle.
  - no fill occurs; all lines invalid.
  - SRAM controller reset is asserted concurrently.
- `sram_ready` outside RD_MISS/WR is ignored.

## Test plan
- After reset: `ready`=1 and both SRAM enables 0. Load 0x400 misses. SRAM (L=5) returns 64'h2222_2222_1111_1111 -> `rdata`=32'h1111_1111 on the `ready` cycle. Load 0x404 then hits with 32'h2222_2222 and zero wait cycles.
- Conflict fill:
  - load 0x400, then 0x400+(1<<9) (same set, different tag) -> second fills way1.
  - third load 0x400+(2<<9) -> evicts way0 (LRU).
  - reload 0x400 -> miss.
- Store 0x400 (cached) with 32'hDEAD_BEEF -> `sram_w_en`=1 with that data until `sram_ready`. The next load of 0x400 misses and refetches.
- Store to uncached 0x800 -> SRAM write only. The following load of 0x800 misses (no allocate).
- `rst`=0 mid-RD_MISS, two cycles after `sram_r_en` rises -> `sram_r_en`=0 and `ready`=1 the next cycle. The previously cached 0x400 now misses.
- `mem_r_en`=`mem_w_en`=1 -> write path taken; `sram_r_en` never asserts.
